// File: rtl/multi_tick_divider_pkg.sv
// multi_tick_pkg: shared mode encoding and timebase defaults for the tick divider and its users
package multi_tick_pkg;
    typedef enum logic {
        MODE_PULSE  = 1'b0,
        MODE_TOGGLE = 1'b1
    } mode_e;
    localparam int CNT_W_DEF       = 26;
    localparam int DEFAULT_DIV_DEF = 50_000_000;
    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/multi_tick_divider_if.sv
// multi_tick_divider_if: control/config inputs and tick outputs of the multi-channel divider
interface multi_tick_divider_if
    import multi_tick_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CNT_W_DEF
);
    localparam int CH_W = ch_w(NUM_CH);
    logic [NUM_CH-1:0] en;
    logic [NUM_CH-1:0] mode;
    logic              sync_clr;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] wave;
    modport master (output en, mode, sync_clr, cfg_we, cfg_ch, cfg_div, input pend, tick, wave);
    modport slave  (input en, mode, sync_clr, cfg_we, cfg_ch, cfg_div, output pend, tick, wave);
endinterface

// File: rtl/multi_tick_divider_tick_channel.sv
// tick_channel: one divider channel with glitch-free divisor apply at wrap, disable or sync clear
module tick_channel
    import multi_tick_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_mode,
    input  logic             i_sync_clr,
    input  logic             i_we,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_pend,
    output logic             o_tick,
    output logic             o_wave
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_pend;
    logic             r_pend;
    logic             r_tick;
    logic             r_wave;
    logic [CNT_W-1:0] w_d;
    logic             w_wrap;
    logic             w_run;
    logic             w_apply;
    assign w_d     = (r_div_act == '0) ? CNT_W'(1) : r_div_act;
    assign w_wrap  = r_cnt >= w_d - CNT_W'(1);
    assign w_run   = i_en && !i_sync_clr;
    assign w_apply = !w_run || w_wrap;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_div_act  <= CNT_W'(DEFAULT_DIV);
            r_div_pend <= CNT_W'(DEFAULT_DIV);
            r_pend     <= 1'b0;
            r_tick     <= 1'b0;
            r_wave     <= 1'b0;
        end else begin
            r_cnt      <= (w_run && !w_wrap) ? r_cnt + CNT_W'(1) : '0;
            r_tick     <= w_run && w_wrap;
            r_wave     <= w_run && (mode_e'(i_mode) == MODE_TOGGLE) && (r_wave ^ w_wrap);
            r_div_pend <= i_we ? i_div : r_div_pend;
            r_div_act  <= w_apply ? (i_we ? i_div : r_div_pend) : r_div_act;
            r_pend     <= !w_apply && (i_we || r_pend);
        end
    end
    assign o_pend = r_pend;
    assign o_tick = r_tick;
    assign o_wave = r_wave;
endmodule

// File: rtl/multi_tick_divider.sv
// multi_tick_divider: N-channel programmable tick/clock-enable generator with shared sync clear
module multi_tick_divider
    import multi_tick_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input logic                 clk,
    input logic                 rst,
    multi_tick_divider_if.slave bus
);
    localparam int CH_W = ch_w(NUM_CH);
    logic [NUM_CH-1:0] w_pend;
    logic [NUM_CH-1:0] w_tick;
    logic [NUM_CH-1:0] w_wave;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        tick_channel #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .i_en      (bus.en[c]),
            .i_mode    (bus.mode[c]),
            .i_sync_clr(bus.sync_clr),
            .i_we      (bus.cfg_we && (bus.cfg_ch == CH_W'(c))),
            .i_div     (bus.cfg_div),
            .o_pend    (w_pend[c]),
            .o_tick    (w_tick[c]),
            .o_wave    (w_wave[c])
        );
    end
    assign bus.pend = w_pend;
    assign bus.tick = w_tick;
    assign bus.wave = w_wave;
endmodule

// File: tb/tb_multi_tick_divider.sv
// tb_multi_tick_divider: table-driven and directed checks of the 2-channel divider
module tb_multi_tick_divider;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass = 0;
    int   n_tot  = 0;
    always #5 clk = ~clk;
    multi_tick_divider_if #(.NUM_CH(2), .CNT_W(8)) bus ();
    multi_tick_divider #(.NUM_CH(2), .CNT_W(8), .DEFAULT_DIV(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    typedef struct packed {
        logic       rst_first;
        logic [1:0] en;
        logic [1:0] mode;
        logic [1:0] tick;
        logic [1:0] wave;
        logic [1:0] pend;
    } vec_t;
    vec_t vt [35];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic drive(input logic [1:0] en, input logic [1:0] mode);
        bus.en   = en;
        bus.mode = mode;
    endtask
    task automatic wr(input logic ch, input logic [7:0] div);
        bus.cfg_we  = 1'b1;
        bus.cfg_ch  = ch;
        bus.cfg_div = div;
        step();
        bus.cfg_we = 1'b0;
    endtask
    task automatic do_reset();
        drive(2'b00, 2'b00);
        bus.sync_clr = 1'b0;
        bus.cfg_we   = 1'b0;
        bus.cfg_ch   = 1'b0;
        bus.cfg_div  = '0;
        rst = 1'b1;
        #3;
        chk("reset_out", {26'd0, bus.tick, bus.wave, bus.pend}, 32'd0);
        step();
        rst = 1'b0;
    endtask
    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [12:0] m0, m1;
        for (int k = 1; k <= 15; k++)
            vt[k-1] = '{k == 1, 2'b01, 2'b00, (k % 5 == 0) ? 2'b01 : 2'b00, 2'b00, 2'b00};
        for (int k = 1; k <= 20; k++)
            vt[14+k] = '{k == 1, 2'b11, 2'b10, (k % 5 == 0) ? 2'b11 : 2'b00,
                         ((k / 5) % 2 == 1) ? 2'b10 : 2'b00, 2'b00};
        for (int i = 0; i < 35; i++) begin
            if (vt[i].rst_first) do_reset();
            drive(vt[i].en, vt[i].mode);
            step();
            chk($sformatf("vec%0d_tick_wave_pend", i), {26'd0, bus.tick, bus.wave, bus.pend},
                {26'd0, vt[i].tick, vt[i].wave, vt[i].pend});
        end
        do_reset();
        drive(2'b01, 2'b00);
        step();
        wr(1'b0, 8'd3);
        chk("upd_pend_set", {30'd0, bus.pend}, 32'd1);
        m0 = '0;
        for (int c = 3; c <= 11; c++) begin
            step();
            m0[c] = bus.tick[0];
            if (c == 4) chk("upd_pend_hold", {30'd0, bus.pend}, 32'd1);
            if (c == 5) chk("upd_pend_clear", {30'd0, bus.pend}, 32'd0);
        end
        chk("upd_tick_spacing", {19'd0, m0}, 32'h0920);
        do_reset();
        wr(1'b1, 8'd0);
        chk("div0_no_pend", {30'd0, bus.pend}, 32'd0);
        drive(2'b10, 2'b00);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("div0_tick%0d", c), {30'd0, bus.tick}, 32'd2);
        end
        drive(2'b00, 2'b00);
        wr(1'b1, 8'd1);
        chk("div1_no_pend_idle", {26'd0, bus.tick, bus.wave, bus.pend}, 32'd0);
        drive(2'b10, 2'b10);
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("div1_wave%0d", c), {28'd0, bus.tick, bus.wave},
                {28'd0, 2'b10, (c % 2 == 0) ? 2'b10 : 2'b00});
        end
        do_reset();
        wr(1'b0, 8'd4);
        wr(1'b1, 8'd6);
        drive(2'b01, 2'b00);
        step();
        step();
        drive(2'b11, 2'b00);
        for (int c = 0; c < 3; c++) step();
        bus.sync_clr = 1'b1;
        step();
        bus.sync_clr = 1'b0;
        chk("sync_clear_out", {26'd0, bus.tick, bus.wave, bus.pend}, 32'd0);
        m0 = '0;
        m1 = '0;
        for (int k = 1; k <= 12; k++) begin
            step();
            m0[k] = bus.tick[0];
            m1[k] = bus.tick[1];
        end
        chk("sync_tick_ch0", {19'd0, m0}, 32'h1110);
        chk("sync_tick_ch1", {19'd0, m1}, 32'h1040);
        wr(1'b0, 8'd2);
        chk("sync_pend_before", {30'd0, bus.pend}, 32'd1);
        bus.sync_clr = 1'b1;
        step();
        bus.sync_clr = 1'b0;
        chk("sync_pend_applied", {28'd0, bus.tick, bus.pend}, 32'd0);
        step();
        chk("sync_d2_first", {31'd0, bus.tick[0]}, 32'd0);
        step();
        chk("sync_d2_tick", {31'd0, bus.tick[0]}, 32'd1);
        do_reset();
        drive(2'b11, 2'b10);
        for (int c = 0; c < 5; c++) step();
        wr(1'b0, 8'd2);
        step();
        step();
        chk("arst_pre_state", {26'd0, bus.tick, bus.wave, bus.pend}, 32'h09);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_immediate", {26'd0, bus.tick, bus.wave, bus.pend}, 32'd0);
        rst = 1'b0;
        m0 = '0;
        for (int k = 1; k <= 5; k++) begin
            step();
            m0[k] = bus.tick[0] & bus.tick[1];
            m1[k] = bus.tick[0] | bus.tick[1];
        end
        chk("arst_first_tick", {19'd0, m0}, 32'h20);
        chk("arst_no_early", {27'd0, m1[4:0]}, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
